alu2_seq_ctrl: RTL and testbench

//   Digit-serial sequencer for the shared 2-bit ALU slice. Accepts one WIDTH-bit

---
 rtl/alu2_seq_ctrl.sv | 112 +++++++++++
 tb/tb_alu2_seq_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu2_seq_ctrl.sv
// rtl/alu2_seq_ctrl.sv - digit-serial sequencer driving the shared 2-bit ALU slice
// Latches one WIDTH-bit operation and walks it through the slice LSB digit first, chaining carry.
module alu2_seq_ctrl #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             zero,
   output logic [DIGIT-1:0] alu_a,
   output logic [DIGIT-1:0] alu_b,
   output logic [1:0]       alu_op,
   output logic             alu_cin,
   input  logic [DIGIT-1:0] alu_y,
   input  logic             alu_cout
);
   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_q, b_q;
   logic [1:0]       op_q;
   logic             carry_q;
   logic             is_sub;
   logic             last_digit;
   logic [31:0]      base;

   assign is_sub     = (op_q == OP_SUB);
   assign last_digit = (cnt == CW'(NDIG - 1));
   assign base       = 32'(cnt) * DIGIT;
   assign zero       = (result == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else if (ena) begin
         state <= state_nxt;
      end
   end

   // Subtraction runs through the adder as a + ~b + 1, so the slice never sees op 01.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      alu_a     = '0;
      alu_b     = '0;
      alu_op    = 2'b00;
      alu_cin   = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_nxt = S_RUN;
         end
         S_RUN: begin
            busy    = 1'b1;
            alu_a   = a_q[base +: DIGIT];
            alu_b   = is_sub ? ~b_q[base +: DIGIT] : b_q[base +: DIGIT];
            alu_op  = is_sub ? OP_ADD : op_q;
            alu_cin = carry_q;
            if (last_digit) state_nxt = S_DONE;
         end
         S_DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= 2'b00;
         cnt       <= '0;
         carry_q   <= 1'b0;
         result    <= '0;
         carry_out <= 1'b0;
      end else if (ena) begin
         if (state == S_IDLE && start) begin
            a_q     <= a;
            b_q     <= b;
            op_q    <= op;
            cnt     <= '0;
            carry_q <= (op == OP_SUB);
            result  <= '0;
         end else if (state == S_RUN) begin
            result[base +: DIGIT] <= alu_y;
            carry_q               <= alu_cout;
            cnt                   <= last_digit ? '0 : cnt + 1'b1;
            // Logic ops report no carry regardless of what the slice returns.
            if (last_digit) carry_out <= op_q[1] ? 1'b0 : alu_cout;
         end
      end
   end
endmodule

// File: tb/tb_alu2_seq_ctrl.sv
// tb/tb_alu2_seq_ctrl.sv - self-checking bench for alu2_seq_ctrl with a behavioural slice and reference model
module tb_alu2_seq_ctrl;
   logic       clk, rst_n, ena, start;
   logic [1:0] op;
   logic [7:0] a, b;
   logic       busy, done, carry_out, zero;
   logic [7:0] result;
   logic [1:0] alu_a, alu_b, alu_op, alu_y;
   logic       alu_cin, alu_cout;

   int checks = 0;
   int errors = 0;

   alu2_seq_ctrl #(.WIDTH(8), .DIGIT(2)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .result(result), .carry_out(carry_out), .zero(zero),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
      .alu_y(alu_y), .alu_cout(alu_cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Combinational 2-bit slice the sequencer drives.
   always_comb begin
      {alu_cout, alu_y} = 3'b000;
      case (alu_op)
         2'b00: {alu_cout, alu_y} = {1'b0, alu_a} + {1'b0, alu_b} + {2'b00, alu_cin};
         2'b10: alu_y = alu_a & alu_b;
         2'b11: alu_y = alu_a ^ alu_b;
         default: {alu_cout, alu_y} = 3'b000;
      endcase
   end

   // Whole-word reference: {carry_out, result}.
   function automatic logic [8:0] ref_op(input logic [7:0] x, input logic [7:0] y, input logic [1:0] o);
      int unsigned s;
      case (o)
         2'b00: begin
            s = 32'(x) + 32'(y);
            return {s > 255, s[7:0]};
         end
         2'b01: return {x >= y, x - y};
         2'b10: return {1'b0, x & y};
         default: return {1'b0, x ^ y};
      endcase
   endfunction

   task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic [1:0] top,
                         input int freeze_at, input int pulse_at,
                         output int lat, output logic [3:0] cins, output int ndone,
                         output logic busy_after);
      lat = -1; cins = '0; ndone = 0; busy_after = 1'b1;
      @(negedge clk);
      a = ta; b = tb_v; op = top; start = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (c == 1) begin
            start = 1'b0;
            a = 8'($urandom);
            b = 8'($urandom);
         end
         if (pulse_at > 0 && c == pulse_at) start = 1'b1;
         if (pulse_at > 0 && c == pulse_at + 1) start = 1'b0;
         if (freeze_at > 0 && c == freeze_at) ena = 1'b0;
         if (freeze_at > 0 && c == freeze_at + 3) ena = 1'b1;
         if (busy && !done && c <= 4) cins[c-1] = alu_cin;
         if (done) begin
            ndone++;
            if (lat < 0) lat = c - 1;
         end
         if (lat >= 0 && c == lat + 2) busy_after = busy;
         if (lat >= 0 && c >= lat + 4) break;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; ena = 1'b1; start = 1'b0; op = 2'b00; a = 8'h00; b = 8'h00;
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
      checks++; if (result !== 8'h00) begin errors++; $display("FAIL reset_result: got %h expected 00", result); end
      checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b expected 0", carry_out); end
      checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero: got %b expected 1", zero); end
      checks++; if ({alu_a, alu_b, alu_op, alu_cin} !== 7'b0) begin errors++;
         $display("FAIL reset_slice: got %b expected 0000000", {alu_a, alu_b, alu_op, alu_cin}); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_directed();
      logic [7:0] va[6]  = '{8'h5A, 8'hFF, 8'h10, 8'h00, 8'hF0, 8'hAA};
      logic [7:0] vb[6]  = '{8'h3C, 8'h01, 8'h01, 8'h01, 8'h3C, 8'hFF};
      logic [1:0] vo[6]  = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b11};
      logic [7:0] vr[6]  = '{8'h96, 8'h00, 8'h0F, 8'hFF, 8'h30, 8'h55};
      logic       vc[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      int lat, nd;
      logic [3:0] cins;
      logic ba;
      for (int i = 0; i < 6; i++) begin
         run_op(va[i], vb[i], vo[i], 0, 0, lat, cins, nd, ba);
         checks++; if (result !== vr[i]) begin errors++; $display("FAIL dir%0d_result: got %h expected %h", i, result, vr[i]); end
         checks++; if (carry_out !== vc[i]) begin errors++; $display("FAIL dir%0d_carry: got %b expected %b", i, carry_out, vc[i]); end
         checks++; if (zero !== (vr[i] == 8'h00)) begin errors++; $display("FAIL dir%0d_zero: got %b expected %b", i, zero, vr[i] == 8'h00); end
         checks++; if (lat !== 4) begin errors++; $display("FAIL dir%0d_latency: got %0d expected 4", i, lat); end
         checks++; if (nd !== 1 || ba !== 1'b0) begin errors++;
            $display("FAIL dir%0d_pulse: got done_count=%0d busy_after=%b expected 1/0", i, nd, ba); end
         if (i == 1) begin
            checks++; if (cins !== 4'b1110) begin errors++; $display("FAIL dir_cin_chain: got %b expected 1110", cins); end
         end
      end
   endtask

   task automatic test_random();
      int lat, nd;
      logic [3:0] cins;
      logic ba;
      logic [7:0] x, y;
      logic [1:0] o;
      logic [8:0] exp_v;
      for (int i = 0; i < 40; i++) begin
         x = 8'($urandom); y = 8'($urandom); o = 2'($urandom_range(0, 3));
         if (i < 4) y = x;
         exp_v = ref_op(x, y, o);
         run_op(x, y, o, 0, 0, lat, cins, nd, ba);
         checks++; if ({carry_out, result} !== exp_v) begin errors++;
            $display("FAIL rnd%0d_value op=%0d a=%h b=%h: got %b_%h expected %b_%h", i, o, x, y, carry_out, result, exp_v[8], exp_v[7:0]); end
         checks++; if (zero !== (exp_v[7:0] == 8'h00)) begin errors++; $display("FAIL rnd%0d_zero: got %b expected %b", i, zero, exp_v[7:0] == 8'h00); end
         checks++; if (lat !== 4) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected 4", i, lat); end
      end
   endtask

   task automatic test_start_during_run();
      int lat, nd;
      logic [3:0] cins;
      logic ba;
      run_op(8'h21, 8'h13, 2'b00, 0, 2, lat, cins, nd, ba);
      checks++; if (nd !== 1) begin errors++; $display("FAIL start_in_run_dones: got %0d expected 1", nd); end
      checks++; if (result !== 8'h34 || lat !== 4) begin errors++;
         $display("FAIL start_in_run_result: got %h lat %0d expected 34 lat 4", result, lat); end
   endtask

   task automatic test_ena_freeze();
      int lat, nd;
      logic [3:0] cins;
      logic ba;
      logic [8:0] exp_v;
      exp_v = ref_op(8'h77, 8'h99, 2'b01);
      run_op(8'h77, 8'h99, 2'b01, 2, 0, lat, cins, nd, ba);
      checks++; if (lat !== 7) begin errors++; $display("FAIL freeze_latency: got %0d expected 7", lat); end
      checks++; if ({carry_out, result} !== exp_v) begin errors++;
         $display("FAIL freeze_value: got %b_%h expected %b_%h", carry_out, result, exp_v[8], exp_v[7:0]); end
      // Freeze while sitting in DONE: the pulse must stretch.
      @(negedge clk);
      a = 8'h01; b = 8'h02; op = 2'b11; start = 1'b1;
      lat = -1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) begin lat = c; break; end
      end
      ena = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (done !== 1'b1 || busy !== 1'b1 || lat < 0) begin errors++;
         $display("FAIL freeze_in_done: got done=%b busy=%b expected 1/1", done, busy); end
      ena = 1'b1;
      @(negedge clk);
      checks++; if (done !== 1'b0 || result !== 8'h03) begin errors++;
         $display("FAIL freeze_release: got done=%b result=%h expected 0/03", done, result); end
   endtask

   task automatic test_reset_mid_run();
      int lat, nd;
      logic [3:0] cins;
      logic ba;
      logic seen;
      @(negedge clk);
      a = 8'hC3; b = 8'h5A; op = 2'b00; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++;
         $display("FAIL rst_mid_state: got busy=%b done=%b expected 0/0", busy, done); end
      checks++; if (result !== 8'h00 || zero !== 1'b1) begin errors++;
         $display("FAIL rst_mid_result: got %h zero=%b expected 00/1", result, zero); end
      seen = 1'b0;
      repeat (3) begin @(negedge clk); if (done) seen = 1'b1; end
      rst_n = 1'b1;
      repeat (4) begin @(negedge clk); if (done) seen = 1'b1; end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_mid_no_done: got %b expected 0", seen); end
      run_op(8'hFF, 8'h01, 2'b00, 0, 0, lat, cins, nd, ba);
      checks++; if ({carry_out, result} !== 9'h100 || lat !== 4) begin errors++;
         $display("FAIL rst_mid_next_op: got %b_%h lat %0d expected 1_00 lat 4", carry_out, result, lat); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] x1, y1, x2, y2;
      logic [1:0] o1, o2;
      logic [8:0] e1, e2, got1;
      int first, second;
      x1 = 8'($urandom); y1 = 8'($urandom); o1 = 2'($urandom_range(0, 3));
      x2 = 8'($urandom); y2 = 8'($urandom); o2 = 2'($urandom_range(0, 3));
      e1 = ref_op(x1, y1, o1); e2 = ref_op(x2, y2, o2);
      got1 = '0; first = -1; second = -1;
      @(negedge clk);
      a = x1; b = y1; op = o1; start = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (c == 1) begin a = x2; b = y2; op = o2; end
         if (done) begin
            if (first < 0) begin first = c; got1 = {carry_out, result}; end
            else if (second < 0 && c > first + 1) second = c;
         end
         if (second >= 0) break;
      end
      start = 1'b0;
      checks++; if (got1 !== e1 || first !== 5) begin errors++;
         $display("FAIL b2b_first: got %b_%h at %0d expected %b_%h at 5", got1[8], got1[7:0], first, e1[8], e1[7:0]); end
      checks++; if ({carry_out, result} !== e2 || second !== 11) begin errors++;
         $display("FAIL b2b_second: got %b_%h at %0d expected %b_%h at 11", carry_out, result, second, e2[8], e2[7:0]); end
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got busy=%b expected 0", busy); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_start_during_run();
      test_ena_freeze();
      test_reset_mid_run();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
